// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: same-cycle IF lookup, EX-side resolve/update and mispredict redirect.
// Optional perf counters are enabled by defining BP_PERF_CNT_EN; otherwise o_br_cnt/o_mispred_cnt read 0.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_pc,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_inst,
    input  logic        i_ex_brc_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_pc,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    logic            valid_q [ENTRIES];
    logic            jal_q   [ENTRIES];
    logic [TAGW-1:0] tag_q   [ENTRIES];
    logic [29:0]     tgt_q   [ENTRIES];
    logic [1:0]      ctr_q   [ENTRIES];

    logic [IDX-1:0]  if_idx;
    logic [TAGW-1:0] if_tag;
    logic            if_hit;

    logic [IDX-1:0]  ex_idx;
    logic [TAGW-1:0] ex_tag;
    logic            ex_hit;
    logic [4:0]      ex_op;
    logic            ex_is_cf;
    logic [31:0]     actual_pc;
    logic [1:0]      ctr_next;

    // The prediction side-band and low/high instruction bits are not needed here.
    logic unused_inputs;
    assign unused_inputs = ^{i_ex_pred_taken, i_ex_inst[31:7], i_ex_inst[1:0]};

    assign if_idx = i_if_pc[IDX+1:2];
    assign if_tag = i_if_pc[31:IDX+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign o_pred_taken = if_hit && (jal_q[if_idx] || ctr_q[if_idx][1]);
    assign o_pred_pc    = o_pred_taken ? {tgt_q[if_idx], 2'b00} : i_if_pc + 32'd4;

    assign ex_idx   = i_ex_pc[IDX+1:2];
    assign ex_tag   = i_ex_pc[31:IDX+2];
    assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_op    = i_ex_inst[6:2];
    assign ex_is_cf = (ex_op == OP_BRANCH) || (ex_op == OP_JAL) || (ex_op == OP_JALR);

    assign actual_pc     = i_ex_brc_taken ? i_ex_target : i_ex_pc + 32'd4;
    assign o_mispredict  = i_rst_n && i_ex_valid && (actual_pc != i_ex_pred_pc);
    assign o_redirect_pc = o_mispredict ? actual_pc : 32'd0;

    always_comb begin
        ctr_next = ctr_q[ex_idx];
        if (i_ex_brc_taken && ctr_q[ex_idx] != 2'b11) begin
            ctr_next = ctr_q[ex_idx] + 2'b01;
        end else if (!i_ex_brc_taken && ctr_q[ex_idx] != 2'b00) begin
            ctr_next = ctr_q[ex_idx] - 2'b01;
        end
    end

    // Writes land at the edge, so a same-cycle lookup of this index still sees the old entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                jal_q[i]   <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (i_ex_valid) begin
            case (ex_op)
                OP_BRANCH: begin
                    if (ex_hit) begin
                        ctr_q[ex_idx] <= ctr_next;
                        if (i_ex_brc_taken) begin
                            tgt_q[ex_idx] <= i_ex_target[31:2];
                        end
                    end else if (i_ex_brc_taken) begin
                        valid_q[ex_idx] <= 1'b1;
                        jal_q[ex_idx]   <= 1'b0;
                        tag_q[ex_idx]   <= ex_tag;
                        tgt_q[ex_idx]   <= i_ex_target[31:2];
                        ctr_q[ex_idx]   <= 2'b10;
                    end
                end
                OP_JAL: begin
                    valid_q[ex_idx] <= 1'b1;
                    jal_q[ex_idx]   <= 1'b1;
                    tag_q[ex_idx]   <= ex_tag;
                    tgt_q[ex_idx]   <= i_ex_target[31:2];
                    ctr_q[ex_idx]   <= 2'b11;
                end
                OP_JALR: begin
                end
                default: begin
                    if (ex_hit) begin
                        valid_q[ex_idx] <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mis_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
        end else begin
            if (i_ex_valid && ex_is_cf) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (o_mispredict) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end

    assign o_br_cnt      = br_cnt_q;
    assign o_mispred_cnt = mis_cnt_q;
`else
    logic unused_cf;
    assign unused_cf     = ex_is_cf;
    assign o_br_cnt      = 32'd0;
    assign o_mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a table-of-records reference model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;

    localparam logic [31:0] INST_BEQ  = 32'h0000_0063;
    localparam logic [31:0] INST_JAL  = 32'h0000_006F;
    localparam logic [31:0] INST_ADDI = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_pc;
    logic        i_ex_valid;
    logic [31:0] i_ex_pc;
    logic [31:0] i_ex_inst;
    logic        i_ex_brc_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_pc;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_br_cnt;
    logic [31:0] o_mispred_cnt;

    int checks = 0;
    int passed = 0;
    bit check_en = 1'b0;

    always #5 i_clk = ~i_clk;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_if_pc         (i_if_pc),
        .o_pred_taken    (o_pred_taken),
        .o_pred_pc       (o_pred_pc),
        .i_ex_valid      (i_ex_valid),
        .i_ex_pc         (i_ex_pc),
        .i_ex_inst       (i_ex_inst),
        .i_ex_brc_taken  (i_ex_brc_taken),
        .i_ex_target     (i_ex_target),
        .i_ex_pred_taken (i_ex_pred_taken),
        .i_ex_pred_pc    (i_ex_pred_pc),
        .o_mispredict    (o_mispredict),
        .o_redirect_pc   (o_redirect_pc),
        .o_br_cnt        (o_br_cnt),
        .o_mispred_cnt   (o_mispred_cnt)
    );

    // Reference model: one record per slot, remembering which PC owns it and how confident it is.
    typedef struct {
        bit          valid;
        bit          is_jal;
        logic [31:0] owner;
        logic [31:0] dest;
        int          strength;
    } ent_t;

    ent_t        m_tab [ENTRIES];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'(ENTRIES));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        ent_t e;
        e = m_tab[slot_of(pc)];
        return e.valid && ((e.owner / 32'(4 * ENTRIES)) == (pc / 32'(4 * ENTRIES)));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        ent_t e;
        e = m_tab[slot_of(pc)];
        return m_hit(pc) && (e.is_jal || e.strength >= 2);
    endfunction

    function automatic logic [31:0] m_pred_pc(input logic [31:0] pc);
        if (m_pred_taken(pc)) return m_tab[slot_of(pc)].dest & 32'hFFFF_FFFC;
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] m_actual();
        return i_ex_brc_taken ? i_ex_target : i_ex_pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        return i_rst_n && i_ex_valid && (m_actual() != i_ex_pred_pc);
    endfunction

    function automatic logic [31:0] exp_br();
`ifdef BP_PERF_CNT_EN
        return m_br;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_mis();
`ifdef BP_PERF_CNT_EN
        return m_mis;
`else
        return 32'd0;
`endif
    endfunction

    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) m_tab[i] = '{1'b0, 1'b0, 32'd0, 32'd0, 1};
            m_br  = 32'd0;
            m_mis = 32'd0;
        end else if (i_ex_valid) begin
            int  s;
            bit  hit;
            s   = slot_of(i_ex_pc);
            hit = m_hit(i_ex_pc);
            if (m_mispredict()) m_mis = m_mis + 32'd1;
            case (i_ex_inst[6:2])
                5'b11000: begin
                    m_br = m_br + 32'd1;
                    if (hit) begin
                        if (i_ex_brc_taken) begin
                            m_tab[s].strength = (m_tab[s].strength < 3) ? m_tab[s].strength + 1 : 3;
                            m_tab[s].dest = i_ex_target;
                        end else begin
                            m_tab[s].strength = (m_tab[s].strength > 0) ? m_tab[s].strength - 1 : 0;
                        end
                    end else if (i_ex_brc_taken) begin
                        m_tab[s] = '{1'b1, 1'b0, i_ex_pc, i_ex_target, 2};
                    end
                end
                5'b11011: begin
                    m_br = m_br + 32'd1;
                    m_tab[s] = '{1'b1, 1'b1, i_ex_pc, i_ex_target, 3};
                end
                5'b11001: m_br = m_br + 32'd1;
                default: if (hit) m_tab[s].valid = 1'b0;
            endcase
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, sampled away from the rising edge.
    always @(negedge i_clk) begin
        if (check_en) begin
            check32("pred_taken",  32'(o_pred_taken), 32'(m_pred_taken(i_if_pc)));
            check32("pred_pc",     o_pred_pc,         m_pred_pc(i_if_pc));
            check32("mispredict",  32'(o_mispredict), 32'(m_mispredict()));
            check32("redirect_pc", o_redirect_pc,     m_mispredict() ? m_actual() : 32'd0);
            check32("br_cnt",      o_br_cnt,          exp_br());
            check32("mispred_cnt", o_mispred_cnt,     exp_mis());
        end
    end

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst, input logic tk,
                                 input logic [31:0] tgt, input logic [31:0] pred);
        i_ex_valid      = 1'b1;
        i_ex_pc         = pc;
        i_ex_inst       = inst;
        i_ex_brc_taken  = tk;
        i_ex_target     = tgt;
        i_ex_pred_pc    = pred;
        i_ex_pred_taken = (pred != pc + 32'd4);
    endtask

    task automatic idle();
        i_ex_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic pt, input logic [31:0] ppc,
                               input logic mis, input logic [31:0] rpc);
        @(negedge i_clk);
        check32({tag, "_pred_taken"}, 32'(o_pred_taken), 32'(pt));
        check32({tag, "_pred_pc"},    o_pred_pc,         ppc);
        check32({tag, "_mispredict"}, 32'(o_mispredict), 32'(mis));
        check32({tag, "_redirect"},   o_redirect_pc,     rpc);
        next_cycle();
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        if ($urandom_range(0, 9) == 0) begin
            r = $urandom();
            return r & 32'hFFFF_FFFC;
        end
        return 32'h100 + 32'd4 * 32'($urandom_range(0, 3 * ENTRIES - 1));
    endfunction

    initial begin
        i_rst_n = 1'b0;
        i_if_pc = 32'h100;
        applyStimulus(32'h100, INST_BEQ, 1'b1, 32'h80, 32'h104);
        next_cycle();
        check_en = 1'b1;
        checkOutput("rst_hold", 1'b0, 32'h104, 1'b0, 32'd0);

        i_rst_n = 1'b1;
        idle();
        checkOutput("post_rst", 1'b0, 32'h104, 1'b0, 32'd0);

        applyStimulus(32'h100, INST_BEQ, 1'b1, 32'h80, 32'h104);
        checkOutput("beq_alloc", 1'b0, 32'h104, 1'b1, 32'h80);
        idle();
        checkOutput("beq_lookup", 1'b1, 32'h80, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(32'h100, INST_BEQ, 1'b1, 32'h80, 32'h80);
            checkOutput("beq_taken", 1'b1, 32'h80, 1'b0, 32'd0);
        end
        applyStimulus(32'h100, INST_BEQ, 1'b0, 32'h80, 32'h80);
        checkOutput("beq_nt1", 1'b1, 32'h80, 1'b1, 32'h104);
        idle();
        checkOutput("ctr_10", 1'b1, 32'h80, 1'b0, 32'd0);
        applyStimulus(32'h100, INST_BEQ, 1'b0, 32'h80, 32'h80);
        checkOutput("beq_nt2", 1'b1, 32'h80, 1'b1, 32'h104);
        idle();
        checkOutput("ctr_01", 1'b0, 32'h104, 1'b0, 32'd0);

        i_if_pc = 32'h200;
        applyStimulus(32'h200, INST_JAL, 1'b1, 32'h400, 32'h204);
        checkOutput("jal_alloc", 1'b0, 32'h204, 1'b1, 32'h400);
        idle();
        checkOutput("jal_lookup", 1'b1, 32'h400, 1'b0, 32'd0);
        applyStimulus(32'h200, INST_JAL, 1'b1, 32'h400, 32'h400);
        checkOutput("jal_repeat", 1'b1, 32'h400, 1'b0, 32'd0);

        i_if_pc = 32'h100;
        applyStimulus(32'h100 + 32'(4 * ENTRIES), INST_BEQ, 1'b1, 32'h300, 32'h144);
        checkOutput("alias_alloc", 1'b0, 32'h104, 1'b1, 32'h300);
        idle();
        checkOutput("alias_miss", 1'b0, 32'h104, 1'b0, 32'd0);
        i_if_pc = 32'h140;
        checkOutput("alias_hit", 1'b1, 32'h300, 1'b0, 32'd0);
        applyStimulus(32'h140, INST_ADDI, 1'b0, 32'd0, 32'h144);
        checkOutput("other_clear", 1'b1, 32'h300, 1'b0, 32'd0);
        idle();
        checkOutput("stale_gone", 1'b0, 32'h144, 1'b0, 32'd0);

        @(negedge i_clk);
`ifdef BP_PERF_CNT_EN
        check32("lit_br_cnt", o_br_cnt, 32'd9);
        check32("lit_mis_cnt", o_mispred_cnt, 32'd5);
`else
        check32("lit_br_cnt", o_br_cnt, 32'd0);
        check32("lit_mis_cnt", o_mispred_cnt, 32'd0);
`endif
        next_cycle();

        i_if_pc = 32'hFFFF_FFFC;
        applyStimulus(32'hFFFF_FFFC, INST_ADDI, 1'b0, 32'd0, 32'd0);
        checkOutput("wrap", 1'b0, 32'd0, 1'b0, 32'd0);

        i_rst_n = 1'b0;
        idle();
        next_cycle();
        i_rst_n = 1'b1;
        i_if_pc = 32'h200;
        @(negedge i_clk);
        check32("rst_br_cnt", o_br_cnt, 32'd0);
        check32("rst_mis_cnt", o_mispred_cnt, 32'd0);
        check32("rst_pred", 32'(o_pred_taken), 32'd0);
        next_cycle();

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            logic [31:0] tgt;
            logic [31:0] inst;
            logic        tk;
            int          sel;
            i_rst_n = ($urandom_range(0, 199) != 0);
            i_if_pc = rand_pc();
            pc      = rand_pc();
            tgt     = rand_pc();
            inst    = $urandom();
            sel     = $urandom_range(0, 3);
            tk      = 1'($urandom_range(0, 1));
            case (sel)
                0: inst[6:2] = 5'b11000;
                1: begin inst[6:2] = 5'b11011; tk = 1'b1; end
                2: begin inst[6:2] = 5'b11001; tk = 1'b1; end
                default: inst[6:2] = tk ? 5'b00100 : 5'b01100;
            endcase
            if (sel == 3) tk = 1'b0;
            case ($urandom_range(0, 2))
                0: applyStimulus(pc, inst, tk, tgt, m_pred_pc(pc));
                1: applyStimulus(pc, inst, tk, tgt, pc + 32'd4);
                default: applyStimulus(pc, inst, tk, tgt, tgt);
            endcase
            i_ex_valid = ($urandom_range(0, 3) != 0);
            next_cycle();
        end

        @(negedge i_clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor sitting at the IF/EX boundary of the forwarding pipeline. IF looks up the fetch PC in a direct-mapped BTB with 2-bit saturating counters and gets a predicted next PC. EX returns the resolved outcome from the branch-taken decision (taken flag plus computed target). The block then updates its tables and raises a one-cycle mispredict/redirect that the hazard unit uses to flush IF/ID and ID/EX.

## Interface
- ENTRIES, 16, BTB/BHT depth; power of two, 4..256; IDX = log2(ENTRIES)
- i_clk  in  1  pipeline clock; all state updates on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_if_pc  in  32  current fetch PC (word aligned)
- o_pred_taken  out  1  predicted taken for i_if_pc
- o_pred_pc  out  32  predicted next PC: target if taken, else i_if_pc+4
- i_ex_valid  in  1  EX holds a valid (not flushed/bubbled) instruction
- i_ex_pc  in  32  PC of the EX instruction
- i_ex_inst  in  32  EX instruction word (opcode bits [6:2] decoded locally)
- i_ex_brc_taken  in  1  resolved taken from EX branch decision
- i_ex_target  in  32  resolved target (PC+imm, or rs1+imm for JALR)
- i_ex_pred_taken  in  1  o_pred_taken piped down with the instruction
- i_ex_pred_pc  in  32  o_pred_pc piped down with the instruction
- o_mispredict  out  1  redirect required this cycle
- o_redirect_pc  out  32  correct next PC when o_mispredict=1
- o_br_cnt  out  32  resolved control-flow instruction count
- o_mispred_cnt  out  32  mispredict count

## Operation
- Index = PC[IDX+1:2]; tag = PC[31:IDX+2]. Entry = {valid, jal, tag, target[31:2], ctr[1:0]}.
- Lookup is combinational from registered arrays.
  - hit = valid && tag match.
  - o_pred_taken = hit && (jal || ctr[1]).
  - o_pred_pc = o_pred_taken ? {target,2'b00} : i_if_pc+4.
- Opcode classes: B_TYPE 11000, JAL 11011, JALR 11001, else OTHER.
- Mispredict (only when i_ex_valid):
  - actual_pc = i_ex_brc_taken ? i_ex_target : i_ex_pc+4.
  - o_mispredict = (actual_pc != i_ex_pred_pc).
  - o_redirect_pc = actual_pc. When not mispredicting, o_redirect_pc = 0.
- Update, at rising edge when i_ex_valid, indexed by i_ex_pc:
  - B_TYPE hit: ctr saturating +1 if taken, -1 if not taken (00 and 11 stick). Target is rewritten on taken.
  - B_TYPE miss and taken: allocate with valid=1, jal=0, ctr=10, target.
  - B_TYPE miss and not taken: no write.
  - JAL: allocate or overwrite with jal=1, ctr=11, target.
  - JALR: no table write. It is always predicted via the table only if an aliased entry exists; correctness comes from the mispredict path.
  - OTHER with hit: clear valid (stale entry).
- Counters saturate within 2 bits; PC+4 wraps modulo 2^32.

## Timing
- Lookup latency 0 cycles (same-cycle prediction for i_if_pc).
- o_mispredict / o_redirect_pc are combinational from EX inputs in the same cycle. The hazard unit registers the redirect.
- Table write becomes visible to lookup the cycle after the update edge.
- Same-index read and write in one cycle: lookup returns the old entry.
- Reset (i_rst_n=0 at an edge):
  - All valid bits 0; ctr 01; jal 0; tag and target 0.
  - Counters o_br_cnt and o_mispred_cnt are 0.
  - While i_rst_n=0, o_mispredict=0 and no updates occur, even if i_ex_valid=1.
  - o_pred_taken=0 after reset until the first allocation.
- i_ex_valid=0: no update, no count, o_mispredict=0.

## Configuration
- BP_PERF_CNT_EN defined:
  - o_br_cnt increments on each valid B_TYPE/JAL/JALR.
  - o_mispred_cnt increments on each o_mispredict.
  - Both are 32-bit, wrap to 0.
- Not defined: both ports tied to 32'd0 and the counter flops are removed. Ports remain so top-level wiring is unchanged.

## Test plan
- Reset, then i_if_pc=0x100 → o_pred_taken=0, o_pred_pc=0x104.
- EX B_TYPE BEQ at 0x100, taken, target 0x80, pred_pc 0x104 → o_mispredict=1, o_redirect_pc=0x80. The next cycle, lookup 0x100 gives o_pred_taken=1, o_pred_pc=0x80.
- Same branch resolved taken 3 more times then not-taken once → ctr 10→11→11→11→10, prediction still taken. A second not-taken gives ctr 01 and predicts 0x104.
- JAL at 0x200 target 0x400 → entry jal=1. Next lookup at 0x200 gives 0x400, and the repeat execution of that JAL (pred_pc 0x400) gives o_mispredict=0.
- Alias: 0x100 and 0x100+4*ENTRIES map to the same index. A taken branch at the second PC replaces the entry, so lookup of 0x100 misses (tag mismatch) and predicts 0x104.
- BP_PERF_CNT_EN build: 5 branches with 2 mispredicts → o_br_cnt=5, o_mispred_cnt=2. Asserting i_rst_n=0 for one edge returns both to 0.
